// File: rtl/bcd_digit_sequencer_pkg.sv
// Shared types and constants for the binary-to-BCD digit sequencer.
package bcd_digit_sequencer_pkg;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned BCD_W    = 4;
  localparam int unsigned VALUE_W  = 13;
  localparam int unsigned COUNT_W  = 2;
  localparam int unsigned DIGITS_W = DIGITS * BCD_W;

  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]  BLANK_RST  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Leading-zero mask: bit k set iff digits k..3 are all zero; ones digit never blanked.
  function automatic logic [DIGITS-1:0] blank_of(input logic [DIGITS_W-1:0] d);
    logic [DIGITS-1:0] b;
    b[0] = 1'b0;
    b[3] = (d[15:12] == 4'd0);
    b[2] = b[3] && (d[11:8] == 4'd0);
    b[1] = b[2] && (d[7:4] == 4'd0);
    return b;
  endfunction

endpackage

// File: rtl/bcd_digit_sequencer_qr.sv
// Combinational divide-by-ten: quotient and BCD remainder of a 13-bit value.
module bcd_digit_sequencer_qr
  import bcd_digit_sequencer_pkg::*;
(
  input  logic [VALUE_W-1:0] dividend,
  output logic [VALUE_W-1:0] quotient,
  output logic [BCD_W-1:0]   remainder
);

  logic [VALUE_W-1:0] product;

  always_comb begin
    quotient  = dividend / VALUE_W'(10);
    product   = quotient * VALUE_W'(10);
    remainder = BCD_W'(dividend - product);
  end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Sequential binary-to-BCD converter: one shared divide-by-ten over four iterations,
// with start/busy/done handshake and leading-zero blanking mask.
module bcd_digit_sequencer
  import bcd_digit_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [VALUE_W-1:0]  value,
  output logic                busy,
  output logic                done,
  output logic [DIGITS_W-1:0] digits,
  output logic [DIGITS-1:0]   blank
);

  state_e              state_q, state_d;
  logic [VALUE_W-1:0]  work_q, work_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [DIGITS_W-1:0] sr_q, sr_d;
  logic [DIGITS_W-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [VALUE_W-1:0]  quo;
  logic [BCD_W-1:0]    rem;

  bcd_digit_sequencer_qr u_qr (
    .dividend  (work_q),
    .quotient  (quo),
    .remainder (rem)
  );

  // Next-state and datapath; remainders enter at the top so the first lands in the ones slot.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    sr_d     = sr_q;
    digits_d = digits_q;
    blank_d  = blank_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = value;
          count_d = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        sr_d    = {rem, sr_q[DIGITS_W-1:BCD_W]};
        work_d  = quo;
        count_d = count_q + COUNT_W'(1);
        if (count_q == COUNT_LAST) begin
          state_d  = ST_DONE;
          digits_d = sr_d;
          blank_d  = blank_of(sr_d);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      count_q  <= '0;
      sr_q     <= '0;
      digits_q <= '0;
      blank_q  <= BLANK_RST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      sr_q     <= sr_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign digits = digits_q;
  assign blank  = blank_q;

endmodule
